// File: rtl/regfile_wb_if.sv
// Writeback bus between the two result paths, the issue-time reserve port
// and the register file write port / scoreboard.
interface regfile_wb_if #(
  parameter int DATA_W = 32
);
  logic              rsv_valid;
  logic [4:0]        rsv_addr;

  logic              a_valid;
  logic [4:0]        a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [4:0]        b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic [31:0]       wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       busy;
  logic              err_dbl_rsv;

  modport master (
    output rsv_valid, rsv_addr,
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  wr_en, wr_data, busy, err_dbl_rsv
  );

  modport slave (
    input  rsv_valid, rsv_addr,
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output wr_en, wr_data, busy, err_dbl_rsv
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a destination scoreboard.
// Define WB_RR_ARB_EN for round-robin arbitration; default is fixed priority (B wins).
//
// Arbiter pointer (round-robin build only)
//   state | meaning
//   PTR_A | A wins the next contested cycle
//   PTR_B | B wins the next contested cycle
module regfile_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  regfile_wb_if.slave wb
);

  logic              prio_a;
  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic [4:0]        xfer_addr;
  logic [DATA_W-1:0] xfer_data;

  logic [31:0]       wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_nxt;
  logic              err_q;
  logic              dbl_rsv;

`ifdef WB_RR_ARB_EN
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e ptr_q;
  ptr_e ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

  // After any grant, priority passes to the requester that was not served.
  always_comb begin
    ptr_nxt = ptr_q;
    if (grant_a) begin
      ptr_nxt = PTR_B;
    end else if (grant_b) begin
      ptr_nxt = PTR_A;
    end
  end

  always_comb begin
    prio_a = (ptr_q == PTR_A);
  end
`else
  always_comb begin
    prio_a = 1'b0;
  end
`endif

  always_comb begin
    grant_a = !rst && wb.a_valid && (!wb.b_valid || prio_a);
    grant_b = !rst && wb.b_valid && !grant_a;
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  always_comb begin
    xfer      = grant_a || grant_b;
    xfer_addr = wb.b_addr;
    xfer_data = wb.b_data;
    if (grant_a) begin
      xfer_addr = wb.a_addr;
      xfer_data = wb.a_data;
    end
  end

  // A reserve landing on a register whose write retires this same cycle is a
  // normal back-to-back reuse, not a double reservation.
  always_comb begin
    dbl_rsv = wb.rsv_valid && (wb.rsv_addr != 5'd0) && busy_q[wb.rsv_addr]
              && !(xfer && (xfer_addr == wb.rsv_addr));
  end

  always_comb begin
    busy_nxt = busy_q;
    if (xfer) begin
      busy_nxt[xfer_addr] = 1'b0;
    end
    if (wb.rsv_valid) begin
      busy_nxt[wb.rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (xfer && (xfer_addr != 5'd0)) begin
        wr_en_q <= 32'd1 << xfer_addr;
      end else begin
        wr_en_q <= '0;
      end
      if (xfer) begin
        wr_data_q <= xfer_data;
      end
      busy_q <= busy_nxt;
      if (dbl_rsv) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb.wr_en       = wr_en_q;
  assign wb.wr_data     = wr_data_q;
  assign wb.busy        = busy_q;
  assign wb.err_dbl_rsv = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed literal checks plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_regfile_wb_arbiter;

`ifdef WB_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_if #(.DATA_W(32)) wb ();

  regfile_wb_arbiter #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the registered outputs must currently show.
  bit [31:0] m_wr_en   = '0;
  bit [31:0] m_wr_data = '0;
  bit [31:0] m_busy    = '0;
  bit        m_err     = 1'b0;
  bit        m_turn_a  = 1'b1;
  bit        started   = 1'b0;

  // Returns {grant_a, grant_b}.
  function automatic logic [1:0] exp_grant(input logic r, input logic av,
                                           input logic bv, input logic turn_a);
    if (r || (!av && !bv)) return 2'b00;
    if (av && !bv) return 2'b10;
    if (bv && !av) return 2'b01;
    return (RR && turn_a) ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk) begin
    logic [1:0]  g;
    logic [4:0]  addr;
    logic [31:0] data;
    g = exp_grant(rst, wb.a_valid, wb.b_valid, m_turn_a);
    addr = g[1] ? wb.a_addr : wb.b_addr;
    data = g[1] ? wb.a_data : wb.b_data;
    started = 1'b1;
    if (rst) begin
      m_wr_en = '0; m_wr_data = '0; m_busy = '0; m_err = 1'b0; m_turn_a = 1'b1;
    end else begin
      m_wr_en = (g != 2'b00 && addr != 0) ? (32'h1 << addr) : 32'h0;
      if (g != 2'b00) m_wr_data = data;
      if (wb.rsv_valid && wb.rsv_addr != 0 && m_busy[wb.rsv_addr]
          && !(g != 2'b00 && addr == wb.rsv_addr))
        m_err = 1'b1;
      if (g != 2'b00 && addr != 0) m_busy[addr] = 1'b0;
      if (wb.rsv_valid && wb.rsv_addr != 0) m_busy[wb.rsv_addr] = 1'b1;
      if (g == 2'b10) m_turn_a = 1'b0;
      else if (g == 2'b01) m_turn_a = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    if (started) begin
      g = exp_grant(rst, wb.a_valid, wb.b_valid, m_turn_a);
      check("a_ready", {31'b0, wb.a_ready}, {31'b0, g[1]});
      check("b_ready", {31'b0, wb.b_ready}, {31'b0, g[0]});
      check("wr_en", wb.wr_en, m_wr_en);
      check("wr_data", wb.wr_data, m_wr_data);
      check("busy", wb.busy, m_busy);
      check("err_dbl_rsv", {31'b0, wb.err_dbl_rsv}, {31'b0, m_err});
      check("wr_en_onehot", {31'b0, ($countones(wb.wr_en) <= 1)}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.rsv_valid = 1'b0; wb.rsv_addr = '0;
    wb.a_valid = 1'b0; wb.a_addr = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = '0; wb.b_data = '0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [31:0] exp_seq [4];

    // Reset with both requesters valid: nothing accepted, everything cleared.
    idle();
    rst = 1'b1;
    wb.a_valid = 1'b1; wb.a_addr = 5'd3; wb.a_data = 32'h1111_1111;
    wb.b_valid = 1'b1; wb.b_addr = 5'd7; wb.b_data = 32'h2222_2222;
    #1;
    check("rst_a_ready", {31'b0, wb.a_ready}, 32'd0);
    check("rst_b_ready", {31'b0, wb.b_ready}, 32'd0);
    tick();
    check("rst_wr_en", wb.wr_en, 32'd0);
    check("rst_wr_data", wb.wr_data, 32'd0);
    check("rst_busy", wb.busy, 32'd0);
    check("rst_err", {31'b0, wb.err_dbl_rsv}, 32'd0);
    rst = 1'b0;
    idle();
    tick();
    check("no_write_after_rst", wb.wr_en, 32'd0);

    // Single A writeback.
    wb.a_valid = 1'b1; wb.a_addr = 5'd5; wb.a_data = 32'hDEAD_BEEF;
    #1;
    check("single_a_ready", {31'b0, wb.a_ready}, 32'd1);
    tick();
    idle();
    check("single_wr_en", wb.wr_en, 32'h0000_0020);
    check("single_wr_data", wb.wr_data, 32'hDEAD_BEEF);
    tick();
    check("single_wr_en_after", wb.wr_en, 32'h0);
    check("single_wr_data_hold", wb.wr_data, 32'hDEAD_BEEF);

    // Contention for four cycles from a freshly reset pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      exp_seq[i] = (RR && (i % 2 == 0)) ? 32'h8 : 32'h80;
    for (int i = 0; i < 4; i++) begin
      wb.a_valid = 1'b1; wb.a_addr = 5'd3; wb.a_data = 32'hA0 + i;
      wb.b_valid = 1'b1; wb.b_addr = 5'd7; wb.b_data = 32'hB0 + i;
      tick();
      check("contend_wr_en", wb.wr_en, exp_seq[i]);
    end
    idle();

    // Reserve r9, retire it two cycles later through B.
    wb.rsv_valid = 1'b1; wb.rsv_addr = 5'd9;
    tick();
    idle();
    check("rsv9_busy_c1", {31'b0, wb.busy[9]}, 32'd1);
    tick();
    check("rsv9_busy_c2", {31'b0, wb.busy[9]}, 32'd1);
    wb.b_valid = 1'b1; wb.b_addr = 5'd9; wb.b_data = 32'h0000_0900;
    tick();
    idle();
    check("rsv9_busy_clr", {31'b0, wb.busy[9]}, 32'd0);
    check("rsv9_wr_en", wb.wr_en, 32'h0000_0200);

    // Reserve and retire r4 in the same cycle, then double-reserve it.
    wb.rsv_valid = 1'b1; wb.rsv_addr = 5'd4;
    tick();
    wb.a_valid = 1'b1; wb.a_addr = 5'd4; wb.a_data = 32'h0000_0444;
    tick();
    idle();
    check("rsv4_same_busy", {31'b0, wb.busy[4]}, 32'd1);
    check("rsv4_same_wr_en", wb.wr_en, 32'h0000_0010);
    wb.rsv_valid = 1'b1; wb.rsv_addr = 5'd4;
    tick();
    idle();
    check("dbl_rsv_err", {31'b0, wb.err_dbl_rsv}, 32'd1);
    check("dbl_rsv_busy", {31'b0, wb.busy[4]}, 32'd1);
    tick();
    tick();
    check("dbl_rsv_sticky", {31'b0, wb.err_dbl_rsv}, 32'd1);

    // Write to r0 is swallowed; then reset with both valid.
    wb.a_valid = 1'b1; wb.a_addr = 5'd0; wb.a_data = 32'h0000_1234;
    #1;
    check("r0_a_ready", {31'b0, wb.a_ready}, 32'd1);
    tick();
    idle();
    check("r0_wr_en", wb.wr_en, 32'h0);
    check("r0_busy", wb.busy, 32'h0000_0010);
    rst = 1'b1;
    wb.a_valid = 1'b1; wb.a_addr = 5'd6; wb.b_valid = 1'b1; wb.b_addr = 5'd2;
    #1;
    check("rst2_a_ready", {31'b0, wb.a_ready}, 32'd0);
    check("rst2_b_ready", {31'b0, wb.b_ready}, 32'd0);
    tick();
    check("rst2_wr_en", wb.wr_en, 32'h0);
    check("rst2_busy", wb.busy, 32'h0);
    check("rst2_err", {31'b0, wb.err_dbl_rsv}, 32'd0);
    rst = 1'b0;
    idle();
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      wb.rsv_valid = ($urandom_range(0, 2) == 0);
      wb.rsv_addr  = rand_addr();
      wb.a_valid   = ($urandom_range(0, 1) == 1);
      wb.a_addr    = rand_addr();
      wb.a_data    = $urandom;
      wb.b_valid   = ($urandom_range(0, 1) == 1);
      wb.b_addr    = rand_addr();
      wb.b_data    = $urandom;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
